// File: rtl/bcd_convert_ctrl_if.sv
// bcd_convert_ctrl_if: start/done handshake and packed BCD result bus of the binary-to-BCD converter.
interface bcd_convert_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
endinterface

// File: rtl/bcd_convert_ctrl.sv
// bcd_convert_ctrl: sequential double-dabble binary-to-BCD converter, one bit per clock, shared add-3 correction.
module bcd_convert_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic               clk,
  input  logic               reset,
  bcd_convert_ctrl_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam longint MAX_BIN = (longint'(1) << WIDTH) - 1;
  localparam longint DEC_RANGE = longint'(10) ** DIGITS;
  if (WIDTH < 4 || WIDTH > 16) begin : g_width_chk
    $error("bcd_convert_ctrl: WIDTH must be 4..16");
  end
  if (DEC_RANGE <= MAX_BIN) begin : g_digits_chk
    $error("bcd_convert_ctrl: DIGITS too small for WIDTH");
  end
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]     work_q, work_d, corr, bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              accept, last;
  logic [BW+WIDTH-1:0] cat;
  assign accept = state_q == IDLE && bus.start;
  assign last   = cnt_q == CW'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (bus.start ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
  end
  // correct every digit before the shift so no digit exceeds 9 afterwards
  always_comb begin
    corr = '0;
    for (int i = 0; i < DIGITS; i++)
      corr[4*i+:4] = work_q[4*i+:4] >= 4'd5 ? work_q[4*i+:4] + 4'd3 : work_q[4*i+:4];
    cat = {corr, bin_q} << 1;
  end
  always_comb begin
    bin_d  = accept ? bus.bin : state_q == SHIFT ? cat[WIDTH-1:0] : bin_q;
    work_d = accept ? '0 : state_q == SHIFT ? cat[BW+WIDTH-1:WIDTH] : work_q;
    cnt_d  = accept ? CW'(WIDTH) : state_q == SHIFT ? cnt_q - CW'(1) : cnt_q;
    bcd_d  = state_q == SHIFT && last ? cat[BW+WIDTH-1:WIDTH] : bcd_q;
    busy_d = state_d == SHIFT;
    done_d = state_q == SHIFT && last;
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
endmodule
